// File: rtl/channel_scan_mux.sv
// Scans CHANNELS packed WIDTH-bit inputs onto one registered output.
// Supports wrap, bounce, one-shot and hold stepping, a skip mask and a pointer load.
module channel_scan_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    localparam int IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk_i,
    input  logic                      clr_i,
    input  logic                      en_i,
    input  logic                      ud_i,
    input  logic [1:0]                mode_i,
    input  logic                      load_i,
    input  logic [IDX_W-1:0]          load_idx_i,
    input  logic [CHANNELS-1:0]       skip_i,
    input  logic [CHANNELS*WIDTH-1:0] data_in_i,
    output logic [WIDTH-1:0]          data_out_o,
    output logic [IDX_W-1:0]          ch_idx_o,
    output logic                      valid_o,
    output logic                      tc_o,
    output logic                      done_o
);

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_BOUNCE  = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_HOLD    = 2'b11;
    localparam int PAD = 1 << IDX_W;

    // Pad to a power of two so every pointer value indexes a real element;
    // padding channels read as masked and are never reached.
    logic [WIDTH-1:0] data_arr [PAD];
    logic [PAD-1:0]   skip_pad;

    genvar gi;
    generate
        for (gi = 0; gi < PAD; gi++) begin : g_unpack
            if (gi < CHANNELS) begin : g_real
                assign data_arr[gi] = data_in_i[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign data_arr[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        skip_pad = '1;
        skip_pad[CHANNELS-1:0] = skip_i;
    end

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    logic [IDX_W-1:0] hi_idx, lo_idx, next_ptr, load_clamped;
    logic             step_dir, turn_dir, cur_masked, at_end, found;
    int               cand;

    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!skip_i[k]) hi_idx = IDX_W'(k);
        end
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (!skip_i[k]) lo_idx = IDX_W'(k);
        end
    end

    assign step_dir   = (mode_i == MODE_BOUNCE) ? dir_q : ud_i;
    assign cur_masked = skip_pad[ptr_q];
    assign at_end     = !cur_masked && (step_dir ? (ptr_q == hi_idx) : (ptr_q == lo_idx));
    // Bounce turns on the endpoint edge so the endpoint is not sampled twice.
    assign turn_dir   = ((mode_i == MODE_BOUNCE) && at_end) ? ~step_dir : step_dir;

    always_comb begin
        next_ptr = ptr_q;
        found    = 1'b0;
        cand     = 0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = turn_dir ? (int'(ptr_q) + k) : (int'(ptr_q) - k);
            if (cand >= CHANNELS)
                cand = cand - CHANNELS;
            else if (cand < 0)
                cand = cand + CHANNELS;
            if (!found && !skip_pad[cand[IDX_W-1:0]]) begin
                next_ptr = cand[IDX_W-1:0];
                found    = 1'b1;
            end
        end
    end

    assign load_clamped = ({1'b0, load_idx_i} >= (IDX_W+1)'(CHANNELS))
                        ? IDX_W'(CHANNELS - 1) : load_idx_i;

    always_comb begin
        ptr_d   = ptr_q;
        dir_d   = (mode_i == MODE_BOUNCE) ? dir_q : ud_i;
        data_d  = data_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        tc_d    = 1'b0;
        done_d  = done_q;
        if (load_i) begin
            ptr_d  = load_clamped;
            done_d = 1'b0;
        end else if (en_i) begin
            if (mode_i == MODE_HOLD) begin
                data_d  = data_arr[ptr_q];
                idx_d   = ptr_q;
                valid_d = ~cur_masked;
            end else if (!done_q) begin
                data_d  = data_arr[ptr_q];
                idx_d   = ptr_q;
                valid_d = ~cur_masked;
                tc_d    = at_end;
                if ((mode_i == MODE_ONESHOT) && at_end)
                    done_d = 1'b1;
                else
                    ptr_d = next_ptr;
                if (mode_i == MODE_BOUNCE)
                    dir_d = turn_dir;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            ptr_q   <= '0;
            dir_q   <= 1'b1;
            data_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            dir_q   <= dir_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign data_out_o = data_q;
    assign ch_idx_o   = idx_q;
    assign valid_o    = valid_q;
    assign tc_o       = tc_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_channel_scan_mux.sv
// Directed bench for channel_scan_mux: default, 3-channel/16-bit and 1-channel instances.
module tb_channel_scan_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr = 1'b1, en = 1'b0, ud = 1'b1, load = 1'b0;
    logic [1:0] mode = 2'b00;

    logic [2:0]  load_idx8 = '0;
    logic [7:0]  skip8 = '0;
    logic [63:0] din8 = {8'hD0, 8'hE7, 8'h88, 8'h99, 8'hCC, 8'hAB, 8'hFF, 8'h11};
    logic [7:0]  dout8;
    logic [2:0]  idx8;
    logic        valid8, tc8, done8;

    logic [1:0]  load_idx3 = '0;
    logic [2:0]  skip3 = '0;
    logic [47:0] din3 = {16'hC003, 16'hB002, 16'hA001};
    logic [15:0] dout3;
    logic [1:0]  idx3;
    logic        valid3, tc3, done3;

    logic        load_idx1 = 1'b0;
    logic        skip1 = 1'b0;
    logic [7:0]  din1 = 8'h5A;
    logic [7:0]  dout1;
    logic        idx1;
    logic        valid1, tc1, done1;

    channel_scan_mux u_dut8 (
        .clk_i(clk), .clr_i(clr), .en_i(en), .ud_i(ud), .mode_i(mode),
        .load_i(load), .load_idx_i(load_idx8), .skip_i(skip8), .data_in_i(din8),
        .data_out_o(dout8), .ch_idx_o(idx8), .valid_o(valid8), .tc_o(tc8), .done_o(done8)
    );

    channel_scan_mux #(.WIDTH(16), .CHANNELS(3)) u_dut3 (
        .clk_i(clk), .clr_i(clr), .en_i(en), .ud_i(ud), .mode_i(mode),
        .load_i(load), .load_idx_i(load_idx3), .skip_i(skip3), .data_in_i(din3),
        .data_out_o(dout3), .ch_idx_o(idx3), .valid_o(valid3), .tc_o(tc3), .done_o(done3)
    );

    channel_scan_mux #(.WIDTH(8), .CHANNELS(1)) u_dut1 (
        .clk_i(clk), .clr_i(clr), .en_i(en), .ud_i(ud), .mode_i(mode),
        .load_i(load), .load_idx_i(load_idx1), .skip_i(skip1), .data_in_i(din1),
        .data_out_o(dout1), .ch_idx_o(idx1), .valid_o(valid1), .tc_o(tc1), .done_o(done1)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_data [8] = '{8'h11, 8'hFF, 8'hAB, 8'hCC, 8'h99, 8'h88, 8'hE7, 8'hD0};
    logic [13:0] got8, want8;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; en = 1'b1; load = 1'b1; load_idx8 = 3'd4;
        tick();
        clr = 1'b0; en = 1'b0; load = 1'b0;
        got8  = {dout8, idx8, valid8, tc8, done8};
        want8 = 14'd0;
        n_cmp++;
        $display("reset  out=%h", got8);
        if (got8 !== want8) begin
            n_err++;
            $display("FAIL reset: got %h want %h", got8, want8);
        end
    endtask

    task automatic test_wrap();
        int seq_dn [4] = '{1, 0, 7, 6};
        int idx;
        mode = 2'b00; ud = 1'b1; en = 1'b1; skip8 = '0;
        for (int i = 0; i < 9; i++) begin
            tick();
            idx   = i % 8;
            got8  = {dout8, idx8, valid8, tc8, done8};
            want8 = {exp_data[idx], 3'(idx), 1'b1, (idx == 7), 1'b0};
            n_cmp++;
            $display("wrap_up  idx=%0d data=%h tc=%b", idx8, dout8, tc8);
            if (got8 !== want8) begin
                n_err++;
                $display("FAIL wrap_up[%0d]: got %h want %h", i, got8, want8);
            end
        end
        ud = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            idx   = seq_dn[i];
            got8  = {dout8, idx8, valid8, tc8, done8};
            want8 = {exp_data[idx], 3'(idx), 1'b1, (idx == 0), 1'b0};
            n_cmp++;
            $display("wrap_dn  idx=%0d data=%h tc=%b", idx8, dout8, tc8);
            if (got8 !== want8) begin
                n_err++;
                $display("FAIL wrap_dn[%0d]: got %h want %h", i, got8, want8);
            end
        end
        en = 1'b0;
        tick();
        got8  = {dout8, idx8, valid8, tc8, done8};
        want8 = {8'hE7, 3'd6, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        $display("idle  idx=%0d data=%h valid=%b", idx8, dout8, valid8);
        if (got8 !== want8) begin
            n_err++;
            $display("FAIL en_low_hold: got %h want %h", got8, want8);
        end
    endtask

    task automatic test_bounce();
        int bseq [17] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
        int idx;
        mode = 2'b01; clr = 1'b1; en = 1'b0;
        tick();
        clr = 1'b0; en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            ud = i[0];
            tick();
            idx   = bseq[i];
            got8  = {dout8, idx8, valid8, tc8, done8};
            want8 = {exp_data[idx], 3'(idx), 1'b1, (i == 7 || i == 14), 1'b0};
            n_cmp++;
            $display("bounce  idx=%0d data=%h tc=%b", idx8, dout8, tc8);
            if (got8 !== want8) begin
                n_err++;
                $display("FAIL bounce[%0d]: got %h want %h", i, got8, want8);
            end
        end
    endtask

    task automatic test_oneshot();
        int oseq [3] = '{5, 6, 7};
        mode = 2'b10; ud = 1'b1; en = 1'b1; load = 1'b1; load_idx8 = 3'd5;
        tick();
        load = 1'b0;
        n_cmp++;
        $display("oneshot_load  valid=%b tc=%b done=%b", valid8, tc8, done8);
        if ({valid8, tc8, done8} !== 3'b000) begin
            n_err++;
            $display("FAIL oneshot_load: got %b want 000", {valid8, tc8, done8});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            got8  = {dout8, idx8, valid8, tc8, done8};
            want8 = {exp_data[oseq[i]], 3'(oseq[i]), 1'b1, (i == 2), (i == 2)};
            n_cmp++;
            $display("oneshot  idx=%0d data=%h tc=%b done=%b", idx8, dout8, tc8, done8);
            if (got8 !== want8) begin
                n_err++;
                $display("FAIL oneshot[%0d]: got %h want %h", i, got8, want8);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            got8  = {dout8, idx8, valid8, tc8, done8};
            want8 = {8'hD0, 3'd7, 1'b0, 1'b0, 1'b1};
            n_cmp++;
            $display("oneshot_done  idx=%0d valid=%b done=%b", idx8, valid8, done8);
            if (got8 !== want8) begin
                n_err++;
                $display("FAIL oneshot_done[%0d]: got %h want %h", i, got8, want8);
            end
        end
        load = 1'b1; load_idx8 = 3'd0;
        tick();
        load = 1'b0;
        n_cmp++;
        $display("oneshot_reload  done=%b", done8);
        if (done8 !== 1'b0) begin
            n_err++;
            $display("FAIL oneshot_reload: done got %b want 0", done8);
        end
        tick();
        got8  = {dout8, idx8, valid8, tc8, done8};
        want8 = {8'h11, 3'd0, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        $display("oneshot_restart  idx=%0d data=%h", idx8, dout8);
        if (got8 !== want8) begin
            n_err++;
            $display("FAIL oneshot_restart: got %h want %h", got8, want8);
        end
    endtask

    task automatic test_skip();
        int sseq [8] = '{1, 3, 5, 7, 1, 3, 5, 7};
        mode = 2'b00; ud = 1'b1; skip8 = 8'b0101_0101;
        clr = 1'b1; tick(); clr = 1'b0;
        tick();
        got8  = {dout8, idx8, valid8, tc8, done8};
        want8 = {8'h11, 3'd0, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        $display("skip_masked  idx=%0d valid=%b", idx8, valid8);
        if (got8 !== want8) begin
            n_err++;
            $display("FAIL skip_masked: got %h want %h", got8, want8);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            got8  = {dout8, idx8, valid8, tc8, done8};
            want8 = {exp_data[sseq[i]], 3'(sseq[i]), 1'b1, (sseq[i] == 7), 1'b0};
            n_cmp++;
            $display("skip  idx=%0d data=%h tc=%b", idx8, dout8, tc8);
            if (got8 !== want8) begin
                n_err++;
                $display("FAIL skip[%0d]: got %h want %h", i, got8, want8);
            end
        end
        skip8 = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            got8  = {dout8, idx8, valid8, tc8, done8};
            want8 = {8'hFF, 3'd1, 1'b0, 1'b0, 1'b0};
            n_cmp++;
            $display("skip_all  idx=%0d valid=%b", idx8, valid8);
            if (got8 !== want8) begin
                n_err++;
                $display("FAIL skip_all[%0d]: got %h want %h", i, got8, want8);
            end
        end
        skip8 = '0;
    endtask

    task automatic test_clr_load();
        mode = 2'b00; ud = 1'b1; en = 1'b1;
        clr = 1'b1; tick(); clr = 1'b0;
        tick(); tick(); tick();
        clr = 1'b1; load = 1'b1; load_idx8 = 3'd6;
        tick();
        clr = 1'b0; load = 1'b0;
        got8  = {dout8, idx8, valid8, tc8, done8};
        n_cmp++;
        $display("clr_load  out=%h", got8);
        if (got8 !== 14'd0) begin
            n_err++;
            $display("FAIL clr_over_load: got %h want 0", got8);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            got8  = {dout8, idx8, valid8, tc8, done8};
            want8 = {exp_data[i], 3'(i), 1'b1, 1'b0, 1'b0};
            n_cmp++;
            $display("after_clr  idx=%0d data=%h", idx8, dout8);
            if (got8 !== want8) begin
                n_err++;
                $display("FAIL after_clr[%0d]: got %h want %h", i, got8, want8);
            end
        end
    endtask

    task automatic test_ch3();
        int tseq [5] = '{0, 1, 2, 1, 0};
        logic [15:0] d3 [3] = '{16'hA001, 16'hB002, 16'hC003};
        logic [20:0] got3, want3;
        mode = 2'b01; en = 1'b1; skip3 = '0;
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ud = i[0];
            tick();
            got3  = {dout3, idx3, valid3, tc3, done3};
            want3 = {d3[tseq[i]], 2'(tseq[i]), 1'b1, (i == 2 || i == 4), 1'b0};
            n_cmp++;
            $display("ch3_bounce  idx=%0d data=%h tc=%b", idx3, dout3, tc3);
            if (got3 !== want3) begin
                n_err++;
                $display("FAIL ch3_bounce[%0d]: got %h want %h", i, got3, want3);
            end
        end
        mode = 2'b00; ud = 1'b1; load = 1'b1; load_idx3 = 2'd3;
        tick();
        load = 1'b0;
        tick();
        got3  = {dout3, idx3, valid3, tc3, done3};
        want3 = {16'hC003, 2'd2, 1'b1, 1'b1, 1'b0};
        n_cmp++;
        $display("ch3_clamp  idx=%0d data=%h", idx3, dout3);
        if (got3 !== want3) begin
            n_err++;
            $display("FAIL ch3_load_clamp: got %h want %h", got3, want3);
        end
    endtask

    task automatic test_ch1();
        logic [11:0] got1, want1;
        logic [1:0]  modes [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
        en = 1'b1;
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mode = modes[i];
            ud   = i[0];
            tick();
            got1  = {dout1, idx1, valid1, tc1, done1};
            want1 = {8'h5A, 1'b0, 1'b1, 1'b1, (i == 4)};
            n_cmp++;
            $display("ch1  mode=%b idx=%0d tc=%b done=%b", mode, idx1, tc1, done1);
            if (got1 !== want1) begin
                n_err++;
                $display("FAIL ch1[%0d]: got %h want %h", i, got1, want1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_bounce();
        test_oneshot();
        test_skip();
        test_clr_load();
        test_ch3();
        test_ch1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
